// File: rtl/cpl_req_credit_sched_pkg.sv
// Shared sizing constants for the completion-request credit scheduler.
package cpl_req_credit_sched_pkg;

  localparam int PORTS_DEF        = 2;
  localparam int S_REQ_TAG_W_DEF  = 5;
  localparam int M_REQ_TAG_W_DEF  = S_REQ_TAG_W_DEF + $clog2(PORTS_DEF);
  localparam int MAX_INFLIGHT_DEF = 8;

  // A single requester still needs a 1-bit index field.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PORT_IDX_W = idx_width(PORTS_DEF);

endpackage

// File: rtl/cpl_req_credit_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant and index of the first requester at or after ptr_i.
// Purely combinational; no grant when req_i is all-zero.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  always_comb begin
    int j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int off = 0; off < N; off++) begin
      j = (int'(ptr_i) + off) % N;
      if (!vld_o && req_i[j]) begin
        vld_o = 1'b1;
        idx_o = IW'(j);
      end
    end
    if (vld_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/cpl_req_credit_sched.sv
// Credit-limited round-robin request scheduler with per-port in-flight tracking and status routing.
// One-cycle request latency through a single output register; status routed one cycle after receipt.
module cpl_req_credit_sched
  import cpl_req_credit_sched_pkg::*;
#(
  parameter int PORTS             = PORTS_DEF,
  parameter int SELECT_WIDTH      = 1,
  parameter int QUEUE_INDEX_WIDTH = 13,
  parameter int S_REQ_TAG_WIDTH   = S_REQ_TAG_W_DEF,
  parameter int M_REQ_TAG_WIDTH   = S_REQ_TAG_WIDTH + $clog2(PORTS),
  parameter int CPL_SIZE          = 32,
  parameter int MAX_INFLIGHT      = MAX_INFLIGHT_DEF,
  parameter int CNT_W             = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PORTS*SELECT_WIDTH-1:0]     s_axis_req_sel,
  input  logic [PORTS*QUEUE_INDEX_WIDTH-1:0] s_axis_req_queue,
  input  logic [PORTS*S_REQ_TAG_WIDTH-1:0]  s_axis_req_tag,
  input  logic [PORTS*CPL_SIZE*8-1:0]       s_axis_req_data,
  input  logic [PORTS-1:0]                  s_axis_req_valid,
  output logic [PORTS-1:0]                  s_axis_req_ready,
  output logic [SELECT_WIDTH-1:0]           m_axis_req_sel,
  output logic [QUEUE_INDEX_WIDTH-1:0]      m_axis_req_queue,
  output logic [M_REQ_TAG_WIDTH-1:0]        m_axis_req_tag,
  output logic [CPL_SIZE*8-1:0]             m_axis_req_data,
  output logic                              m_axis_req_valid,
  input  logic                              m_axis_req_ready,
  input  logic [M_REQ_TAG_WIDTH-1:0]        s_axis_req_status_tag,
  input  logic                              s_axis_req_status_full,
  input  logic                              s_axis_req_status_error,
  input  logic                              s_axis_req_status_valid,
  output logic [PORTS*S_REQ_TAG_WIDTH-1:0]  m_axis_req_status_tag,
  output logic [PORTS-1:0]                  m_axis_req_status_full,
  output logic [PORTS-1:0]                  m_axis_req_status_error,
  output logic [PORTS-1:0]                  m_axis_req_status_valid,
  output logic [PORTS*CNT_W-1:0]            inflight_count,
  output logic [PORTS-1:0]                  credit_underflow
);

  localparam int IW = idx_width(PORTS);
  localparam int HW = M_REQ_TAG_WIDTH - S_REQ_TAG_WIDTH;
  localparam int DW = CPL_SIZE * 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

  logic                         req_vld_q;
  logic [SELECT_WIDTH-1:0]      req_sel_q;
  logic [QUEUE_INDEX_WIDTH-1:0] req_queue_q;
  logic [M_REQ_TAG_WIDTH-1:0]   req_tag_q;
  logic [DW-1:0]                req_data_q;
  logic [IW-1:0]                rr_ptr_q, rr_ptr_d;
  logic [PORTS-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [PORTS-1:0]             unf_q, unf_d;
  logic [PORTS-1:0]             st_vld_q, st_full_q, st_err_q;
  logic [S_REQ_TAG_WIDTH-1:0]   st_tag_q;

  logic [PORTS-1:0] eligible, arb_req, gnt;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_vld, can_load;
  logic [HW-1:0]    st_port;
  logic             st_hit;

  always_comb begin
    eligible = '0;
    can_load = !req_vld_q || m_axis_req_ready;
    for (int i = 0; i < PORTS; i++)
      eligible[i] = s_axis_req_valid[i] && (cnt_q[i] < CNT_MAX);
    arb_req = (can_load && !rst) ? eligible : '0;
  end

  rr_arbiter #(.N(PORTS), .IW(IW)) u_arb (
    .req_i (arb_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .vld_o (gnt_vld)
  );

  assign s_axis_req_ready = gnt;
  assign rr_ptr_d = (int'(gnt_idx) == PORTS - 1) ? '0 : gnt_idx + 1'b1;

  // Statuses naming a port index beyond PORTS are ignored entirely.
  assign st_port = s_axis_req_status_tag[M_REQ_TAG_WIDTH-1:S_REQ_TAG_WIDTH];
  assign st_hit  = s_axis_req_status_valid && (int'(st_port) < PORTS);

  always_comb begin
    cnt_d = cnt_q;
    unf_d = unf_q;
    for (int i = 0; i < PORTS; i++) begin
      if (gnt[i] && !(st_hit && int'(st_port) == i)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (!gnt[i] && st_hit && int'(st_port) == i) begin
        if (cnt_q[i] == '0) unf_d[i] = 1'b1;
        else                cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_vld_q   <= 1'b0;
      req_sel_q   <= '0;
      req_queue_q <= '0;
      req_tag_q   <= '0;
      req_data_q  <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      unf_q       <= '0;
    end else begin
      if (can_load) req_vld_q <= gnt_vld;
      if (gnt_vld) begin
        req_sel_q   <= s_axis_req_sel[gnt_idx*SELECT_WIDTH +: SELECT_WIDTH];
        req_queue_q <= s_axis_req_queue[gnt_idx*QUEUE_INDEX_WIDTH +: QUEUE_INDEX_WIDTH];
        req_tag_q   <= M_REQ_TAG_WIDTH'({gnt_idx, s_axis_req_tag[gnt_idx*S_REQ_TAG_WIDTH +: S_REQ_TAG_WIDTH]});
        req_data_q  <= s_axis_req_data[gnt_idx*DW +: DW];
        rr_ptr_q    <= rr_ptr_d;
      end
      cnt_q <= cnt_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_vld_q  <= '0;
      st_full_q <= '0;
      st_err_q  <= '0;
      st_tag_q  <= '0;
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        st_vld_q[p]  <= st_hit && int'(st_port) == p;
        st_full_q[p] <= st_hit && int'(st_port) == p && s_axis_req_status_full;
        st_err_q[p]  <= st_hit && int'(st_port) == p && s_axis_req_status_error;
      end
      st_tag_q <= s_axis_req_status_tag[S_REQ_TAG_WIDTH-1:0];
    end
  end

  assign m_axis_req_valid        = req_vld_q;
  assign m_axis_req_sel          = req_sel_q;
  assign m_axis_req_queue        = req_queue_q;
  assign m_axis_req_tag          = req_tag_q;
  assign m_axis_req_data         = req_data_q;
  assign m_axis_req_status_valid = st_vld_q;
  assign m_axis_req_status_full  = st_full_q;
  assign m_axis_req_status_error = st_err_q;
  assign m_axis_req_status_tag   = {PORTS{st_tag_q}};
  assign inflight_count          = cnt_q;
  assign credit_underflow        = unf_q;

endmodule

// File: tb/tb_cpl_req_credit_sched.sv
// Bench for cpl_req_credit_sched: directed scenarios plus random traffic against a queue-free reference model.
module tb_cpl_req_credit_sched;

  localparam int P    = 2;
  localparam int SELW = 1;
  localparam int QW   = 13;
  localparam int STW  = 5;
  localparam int MTW  = 6;
  localparam int DW   = 256;
  localparam int MAXI = 8;
  localparam int CW   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [P*SELW-1:0] s_sel;
  logic [P*QW-1:0]   s_queue;
  logic [P*STW-1:0]  s_tag;
  logic [P*DW-1:0]   s_data;
  logic [P-1:0]      s_valid, s_ready;
  logic [SELW-1:0]   m_sel;
  logic [QW-1:0]     m_queue;
  logic [MTW-1:0]    m_tag;
  logic [DW-1:0]     m_data;
  logic              m_valid, m_ready;
  logic [MTW-1:0]    st_tag_in;
  logic              st_full_in, st_err_in, st_valid_in;
  logic [P*STW-1:0]  ms_tag;
  logic [P-1:0]      ms_full, ms_err, ms_valid;
  logic [P*CW-1:0]   inflight;
  logic [P-1:0]      underflow;

  cpl_req_credit_sched dut (
    .clk(clk), .rst(rst),
    .s_axis_req_sel(s_sel), .s_axis_req_queue(s_queue), .s_axis_req_tag(s_tag),
    .s_axis_req_data(s_data), .s_axis_req_valid(s_valid), .s_axis_req_ready(s_ready),
    .m_axis_req_sel(m_sel), .m_axis_req_queue(m_queue), .m_axis_req_tag(m_tag),
    .m_axis_req_data(m_data), .m_axis_req_valid(m_valid), .m_axis_req_ready(m_ready),
    .s_axis_req_status_tag(st_tag_in), .s_axis_req_status_full(st_full_in),
    .s_axis_req_status_error(st_err_in), .s_axis_req_status_valid(st_valid_in),
    .m_axis_req_status_tag(ms_tag), .m_axis_req_status_full(ms_full),
    .m_axis_req_status_error(ms_err), .m_axis_req_status_valid(ms_valid),
    .inflight_count(inflight), .credit_underflow(underflow)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int              cnt[P];
  bit              unf[P];
  int              rr;
  bit              ov;
  int              op;
  logic [SELW-1:0] osel;
  logic [QW-1:0]   oqueue;
  logic [STW-1:0]  otag;
  logic [DW-1:0]   odata;
  bit              sv[P], sfull[P], serr[P];
  logic [STW-1:0]  stag;
  logic [P-1:0]    exp_rdy, obs_rdy;

  function automatic logic [MTW-1:0] exp_mtag();
    return MTW'(op * (1 << STW) + int'(otag));
  endfunction

  function automatic logic [P*CW-1:0] exp_counts();
    logic [P*CW-1:0] v;
    v = '0;
    for (int i = 0; i < P; i++) v[i*CW +: CW] = CW'(cnt[i]);
    return v;
  endfunction

  function automatic logic [P-1:0] pack_bits(input bit b0, input bit b1);
    return {b1, b0};
  endfunction

  task automatic idle_inputs();
    s_valid = '0; m_ready = 1'b1;
    st_valid_in = 1'b0; st_tag_in = '0; st_full_in = 1'b0; st_err_in = 1'b0;
  endtask

  task automatic rand_fields();
    for (int p = 0; p < P; p++) begin
      s_sel[p*SELW +: SELW] = SELW'($urandom);
      s_queue[p*QW +: QW]   = QW'($urandom);
      s_tag[p*STW +: STW]   = STW'($urandom);
      for (int w = 0; w < DW/32; w++) s_data[p*DW + w*32 +: 32] = $urandom;
    end
  endtask

  // Inputs are set at a negedge; this samples ready, advances model and DUT one edge, returns at the next negedge.
  task automatic step();
    int g, sp;
    bit hit;
    g = -1;
    if (!rst && (!ov || m_ready))
      for (int k = 0; k < P; k++)
        if (g < 0 && s_valid[(rr + k) % P] && cnt[(rr + k) % P] < MAXI) g = (rr + k) % P;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    #1 obs_rdy = s_ready;
    @(posedge clk);
    if (rst) begin
      ov = 0; rr = 0; stag = '0;
      for (int i = 0; i < P; i++) begin cnt[i] = 0; unf[i] = 0; sv[i] = 0; sfull[i] = 0; serr[i] = 0; end
    end else begin
      if (!ov || m_ready) ov = (g >= 0);
      if (g >= 0) begin
        op = g; osel = s_sel[g*SELW +: SELW]; oqueue = s_queue[g*QW +: QW];
        otag = s_tag[g*STW +: STW]; odata = s_data[g*DW +: DW];
        rr = (g + 1) % P;
      end
      sp  = int'(st_tag_in[MTW-1:STW]);
      hit = st_valid_in && sp < P;
      for (int i = 0; i < P; i++) begin
        if (g == i && !(hit && sp == i)) cnt[i]++;
        else if (g != i && hit && sp == i) begin
          if (cnt[i] == 0) unf[i] = 1; else cnt[i]--;
        end
        sv[i]    = hit && sp == i;
        sfull[i] = sv[i] && st_full_in;
        serr[i]  = sv[i] && st_err_in;
      end
      stag = st_tag_in[STW-1:0];
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; idle_inputs();
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs(); rand_fields(); s_valid = '1;
    step();
    step();
    vectors++; if (obs_rdy !== 2'b00) begin miscompares++; $display("FAIL reset_rdy got=%b exp=00", obs_rdy); end
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mvalid got=%b exp=0", m_valid); end
    vectors++; if (m_data !== '0 || m_tag !== '0) begin miscompares++; $display("FAIL reset_mdata tag=%h exp=0", m_tag); end
    vectors++; if (inflight !== '0) begin miscompares++; $display("FAIL reset_counts got=%h exp=0", inflight); end
    vectors++; if (underflow !== '0 || ms_valid !== '0) begin miscompares++; $display("FAIL reset_status unf=%b sv=%b exp=0", underflow, ms_valid); end
    rst = 1'b0; s_valid = '0;
  endtask

  task automatic test_alternate();
    logic [MTW-1:0] want[4];
    logic [P-1:0]   rdy_want[2];
    want[0] = 6'h0A; want[1] = 6'h2B; want[2] = 6'h0A; want[3] = 6'h2B;
    rdy_want[0] = 2'b01; rdy_want[1] = 2'b10;
    do_reset(); rand_fields();
    s_tag[0*STW +: STW] = 5'h0A; s_tag[1*STW +: STW] = 5'h0B;
    s_valid = 2'b11; m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      vectors++; if (obs_rdy !== rdy_want[k%2]) begin miscompares++; $display("FAIL alt_rdy k=%0d got=%b exp=%b", k, obs_rdy, rdy_want[k%2]); end
      vectors++; if (m_valid !== 1'b1 || m_tag !== want[k]) begin miscompares++; $display("FAIL alt_tag k=%0d got=%h/%b exp=%h/1", k, m_tag, m_valid, want[k]); end
      vectors++; if (m_data !== odata || m_queue !== oqueue || m_sel !== osel) begin miscompares++; $display("FAIL alt_data k=%0d queue=%h exp=%h", k, m_queue, oqueue); end
    end
  endtask

  task automatic test_credit_limit();
    do_reset(); rand_fields();
    s_valid = 2'b01; m_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      vectors++; if (obs_rdy !== 2'b01) begin miscompares++; $display("FAIL cred_fill k=%0d got=%b exp=01", k, obs_rdy); end
    end
    vectors++; if (inflight[CW-1:0] !== 4'd8) begin miscompares++; $display("FAIL cred_count got=%0d exp=8", inflight[CW-1:0]); end
    s_valid = 2'b11;
    step();
    vectors++; if (obs_rdy !== 2'b10) begin miscompares++; $display("FAIL cred_block got=%b exp=10", obs_rdy); end
    s_valid = 2'b01; st_valid_in = 1'b1; st_tag_in = 6'h03;
    step();
    vectors++; if (obs_rdy !== 2'b00) begin miscompares++; $display("FAIL cred_still_full got=%b exp=00", obs_rdy); end
    vectors++; if (inflight[CW-1:0] !== 4'd7) begin miscompares++; $display("FAIL cred_release got=%0d exp=7", inflight[CW-1:0]); end
    st_valid_in = 1'b0;
    step();
    vectors++; if (obs_rdy !== 2'b01) begin miscompares++; $display("FAIL cred_resume got=%b exp=01", obs_rdy); end
    vectors++; if (inflight !== exp_counts()) begin miscompares++; $display("FAIL cred_model got=%h exp=%h", inflight, exp_counts()); end
  endtask

  task automatic test_stall();
    logic [MTW-1:0] tag0;
    logic [DW-1:0]  data0;
    do_reset(); rand_fields();
    s_valid = 2'b01; m_ready = 1'b1;
    step();
    tag0 = exp_mtag(); data0 = odata;
    s_valid = 2'b11; m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_fields();
      step();
      vectors++; if (obs_rdy !== 2'b00) begin miscompares++; $display("FAIL stall_rdy k=%0d got=%b exp=00", k, obs_rdy); end
      vectors++; if (m_valid !== 1'b1 || m_tag !== tag0 || m_data !== data0) begin miscompares++; $display("FAIL stall_hold k=%0d tag=%h exp=%h", k, m_tag, tag0); end
    end
    m_ready = 1'b1;
    step();
    vectors++; if (obs_rdy !== 2'b10) begin miscompares++; $display("FAIL stall_drain got=%b exp=10", obs_rdy); end
    vectors++; if (m_tag !== exp_mtag() || m_data !== odata) begin miscompares++; $display("FAIL stall_next tag=%h exp=%h", m_tag, exp_mtag()); end
  endtask

  task automatic test_status_route();
    do_reset();
    st_valid_in = 1'b1; st_tag_in = 6'h25; st_full_in = 1'b1; st_err_in = 1'b0;
    step();
    st_valid_in = 1'b0; st_full_in = 1'b0;
    vectors++; if (ms_valid !== 2'b10) begin miscompares++; $display("FAIL st_valid got=%b exp=10", ms_valid); end
    vectors++; if (ms_tag[STW +: STW] !== 5'h05) begin miscompares++; $display("FAIL st_tag got=%h exp=05", ms_tag[STW +: STW]); end
    vectors++; if (ms_full !== 2'b10 || ms_err !== 2'b00) begin miscompares++; $display("FAIL st_flags full=%b err=%b exp=10/00", ms_full, ms_err); end
    step();
    vectors++; if (ms_valid !== 2'b00) begin miscompares++; $display("FAIL st_oneshot got=%b exp=00", ms_valid); end
  endtask

  task automatic test_underflow();
    do_reset();
    st_valid_in = 1'b1; st_tag_in = 6'h20; st_err_in = 1'b1;
    step();
    st_valid_in = 1'b0; st_err_in = 1'b0;
    vectors++; if (inflight !== '0) begin miscompares++; $display("FAIL unf_count got=%h exp=0", inflight); end
    vectors++; if (underflow !== 2'b10 || ms_err !== 2'b10) begin miscompares++; $display("FAIL unf_flag got=%b err=%b exp=10", underflow, ms_err); end
    for (int k = 0; k < 3; k++) step();
    vectors++; if (underflow !== 2'b10) begin miscompares++; $display("FAIL unf_sticky got=%b exp=10", underflow); end
  endtask

  task automatic test_coincide_and_reset();
    do_reset(); rand_fields();
    s_valid = 2'b01; m_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    st_valid_in = 1'b1; st_tag_in = 6'h00;
    step();
    st_valid_in = 1'b0;
    vectors++; if (obs_rdy !== 2'b01) begin miscompares++; $display("FAIL coin_rdy got=%b exp=01", obs_rdy); end
    vectors++; if (inflight[CW-1:0] !== 4'd3) begin miscompares++; $display("FAIL coin_count got=%0d exp=3", inflight[CW-1:0]); end
    m_ready = 1'b0;
    step();
    vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL coin_stall got=%b exp=1", m_valid); end
    rst = 1'b1;
    step();
    vectors++; if (obs_rdy !== 2'b00) begin miscompares++; $display("FAIL rst_rdy got=%b exp=00", obs_rdy); end
    vectors++; if (m_valid !== 1'b0 || inflight !== '0) begin miscompares++; $display("FAIL rst_midstall valid=%b counts=%h exp=0/0", m_valid, inflight); end
    rst = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rand_fields();
      s_valid     = P'($urandom);
      m_ready     = ($urandom_range(0, 9) < 7);
      st_valid_in = ($urandom_range(0, 3) == 0);
      st_tag_in   = MTW'($urandom);
      st_full_in  = 1'(($urandom));
      st_err_in   = 1'(($urandom));
      step();
      vectors++; if (obs_rdy !== exp_rdy) begin miscompares++; $display("FAIL rnd_rdy c=%0d got=%b exp=%b", c, obs_rdy, exp_rdy); end
      vectors++; if (m_valid !== ov) begin miscompares++; $display("FAIL rnd_mvalid c=%0d got=%b exp=%b", c, m_valid, ov); end
      if (ov) begin
        vectors++;
        if (m_tag !== exp_mtag() || m_sel !== osel || m_queue !== oqueue || m_data !== odata) begin
          miscompares++; $display("FAIL rnd_payload c=%0d tag=%h exp=%h queue=%h exp=%h", c, m_tag, exp_mtag(), m_queue, oqueue);
        end
      end
      vectors++; if (inflight !== exp_counts()) begin miscompares++; $display("FAIL rnd_counts c=%0d got=%h exp=%h", c, inflight, exp_counts()); end
      vectors++; if (underflow !== pack_bits(unf[0], unf[1])) begin miscompares++; $display("FAIL rnd_unf c=%0d got=%b exp=%b", c, underflow, pack_bits(unf[0], unf[1])); end
      vectors++;
      if (ms_valid !== pack_bits(sv[0], sv[1]) || ms_full !== pack_bits(sfull[0], sfull[1]) || ms_err !== pack_bits(serr[0], serr[1])) begin
        miscompares++; $display("FAIL rnd_status c=%0d v=%b f=%b e=%b exp=%b", c, ms_valid, ms_full, ms_err, pack_bits(sv[0], sv[1]));
      end
      for (int p = 0; p < P; p++)
        if (sv[p]) begin
          vectors++;
          if (ms_tag[p*STW +: STW] !== stag) begin miscompares++; $display("FAIL rnd_sttag c=%0d p=%0d got=%h exp=%h", c, p, ms_tag[p*STW +: STW], stag); end
        end
    end
  endtask

  initial begin
    rst = 1'b1; s_sel = '0; s_queue = '0; s_tag = '0; s_data = '0;
    idle_inputs();
    ov = 0; rr = 0; op = 0; osel = '0; oqueue = '0; otag = '0; odata = '0; stag = '0;
    for (int i = 0; i < P; i++) begin cnt[i] = 0; unf[i] = 0; sv[i] = 0; sfull[i] = 0; serr[i] = 0; end
    @(negedge clk);
    test_reset();
    test_alternate();
    test_credit_limit();
    test_stall();
    test_status_route();
    test_underflow();
    test_coincide_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
